// File: rtl/fpsqrt_req_arbiter.sv
// fpsqrt_req_arbiter: round-robin sharing of one fpsqrt_vector_r16 unit among NUM_REQ requesters
// Ports:
//   clk, rst_n (sync, active-low), flush_i aborts the outstanding operation
//   req_*   : per-requester command valid/ready, operands, format, rm, vector mode, tag
//   resp_*  : per-requester result valid/ready plus shared result, fflags and tag buses
//   sqrt_*  : registered command, start/finish handshakes, flush and result from the unit
//   busy_o, owner_o : status
module fpsqrt_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W = 4,
   localparam int OWN_W = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*64-1:0]    req_op_i,
   input  logic [NUM_REQ*2-1:0]     req_fp_format_i,
   input  logic [NUM_REQ*3-1:0]     req_rm_i,
   input  logic [NUM_REQ-1:0]       req_vector_mode_i,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
   output logic [NUM_REQ-1:0]       resp_valid_o,
   input  logic [NUM_REQ-1:0]       resp_ready_i,
   output logic [63:0]              resp_res_o,
   output logic [4:0]               resp_fflags_o,
   output logic [TAG_W-1:0]         resp_tag_o,
   output logic                     sqrt_start_valid_o,
   input  logic                     sqrt_start_ready_i,
   output logic [63:0]              sqrt_op_o,
   output logic [1:0]               sqrt_fp_format_o,
   output logic [2:0]               sqrt_rm_o,
   output logic                     sqrt_vector_mode_o,
   output logic                     sqrt_flush_o,
   input  logic                     sqrt_finish_valid_i,
   output logic                     sqrt_finish_ready_o,
   input  logic [63:0]              sqrt_res_i,
   input  logic [4:0]               sqrt_fflags_i,
   output logic                     busy_o,
   output logic [OWN_W-1:0]         owner_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, nxt;
   logic [OWN_W-1:0] rr_ptr, owner, g, ofs, nxt_ptr;
   logic [OWN_W:0] sum;
   logic [NUM_REQ-1:0] rot;
   logic any, req_hs, start_hs, fin_hs, resp_hs, abort;
   logic [63:0] op, res;
   logic [1:0] fmt;
   logic [2:0] rm;
   logic vm;
   logic [4:0] ff;
   logic [TAG_W-1:0] tag;
   // rotate valids so bit 0 is rr_ptr; lowest set bit is the offset of the grant
   always_comb begin
      rot = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr);
      any = |req_valid_i;
      ofs = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (rot[i]) ofs = OWN_W'(i);
      sum = {1'b0, rr_ptr} + {1'b0, ofs};
      g = (sum >= (OWN_W+1)'(NUM_REQ)) ? OWN_W'(sum - (OWN_W+1)'(NUM_REQ)) : OWN_W'(sum);
      nxt_ptr = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   end
   always_comb begin
      abort = flush_i && state != IDLE;
      req_hs = state == IDLE && !flush_i && any;
      req_ready_o = req_hs ? NUM_REQ'(1) << g : '0;
      sqrt_start_valid_o = state == ISSUE && !flush_i;
      sqrt_finish_ready_o = state == WAIT && !flush_i;
      resp_valid_o = (state == RESP && !flush_i) ? NUM_REQ'(1) << owner : '0;
      start_hs = sqrt_start_valid_o && sqrt_start_ready_i;
      fin_hs = sqrt_finish_ready_o && sqrt_finish_valid_i;
      resp_hs = state == RESP && !flush_i && resp_ready_i[owner];
      sqrt_flush_o = abort;
      busy_o = state != IDLE;
      nxt = state;
      case (state)
         IDLE:  nxt = req_hs ? ISSUE : IDLE;
         ISSUE: nxt = start_hs ? WAIT : ISSUE;
         WAIT:  nxt = fin_hs ? RESP : WAIT;
         RESP:  nxt = resp_hs ? IDLE : RESP;
         default: nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   always_ff @(posedge clk)
      state <= !rst_n ? IDLE : nxt;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         owner <= '0;
         op <= '0;
         fmt <= '0;
         rm <= '0;
         vm <= 1'b0;
         tag <= '0;
         res <= '0;
         ff <= '0;
      end else begin
         if (req_hs) begin
            op <= req_op_i[int'(g)*64 +: 64];
            fmt <= req_fp_format_i[int'(g)*2 +: 2];
            rm <= req_rm_i[int'(g)*3 +: 3];
            vm <= req_vector_mode_i[g];
            tag <= req_tag_i[int'(g)*TAG_W +: TAG_W];
            owner <= g;
         end
         if (fin_hs) begin
            res <= sqrt_res_i;
            ff <= sqrt_fflags_i;
         end
         if (resp_hs || abort) rr_ptr <= nxt_ptr;
      end
   end
   assign sqrt_op_o = op;
   assign sqrt_fp_format_o = fmt;
   assign sqrt_rm_o = rm;
   assign sqrt_vector_mode_o = vm;
   assign resp_res_o = res;
   assign resp_fflags_o = ff;
   assign resp_tag_o = tag;
   assign owner_o = owner;
endmodule
